// File: rtl/cu_pkg.sv
// Shared constants and types for the compute-unit sequencer.
package cu_pkg;

  // Unit codes carried on op_unit
  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_SHF = 2'd2;
  localparam logic [1:0] UNIT_RSV = 2'd3;

  // One-hot crossbar compute-write selects
  localparam logic [2:0] WSEL_ALU = 3'b001;
  localparam logic [2:0] WSEL_SHF = 3'b010;
  localparam logic [2:0] WSEL_MUL = 3'b100;

  // op_func field offsets, ALU: {sat, sc[2:0], hc[1:0], log}
  localparam int unsigned ALU_LOG_BIT = 0;
  localparam int unsigned ALU_HC_LSB  = 1;
  localparam int unsigned ALU_SC_LSB  = 3;
  localparam int unsigned ALU_SAT_BIT = 6;

  // Multiplier: {cls[1:0], dtsts[3:0], otreg}
  localparam int unsigned MUL_OTREG_BIT = 0;
  localparam int unsigned MUL_DTSTS_LSB = 1;
  localparam int unsigned MUL_CLS_LSB   = 5;

  // Shifter: {5'b0, cls[1:0]}
  localparam int unsigned SHF_CLS_LSB = 0;

  typedef struct packed {
    logic       alu_en;
    logic       alu_log;
    logic       alu_sat;
    logic [1:0] alu_hc;
    logic [2:0] alu_sc;
    logic       mul_en;
    logic       mul_otreg;
    logic [3:0] mul_dtsts;
    logic [1:0] mul_cls;
    logic       shf_en;
    logic [1:0] shf_cls;
  } cu_ctrl_t;

  // Write select for a unit; reserved unit never writes back
  function automatic logic [2:0] unit_wsel(input logic [1:0] unit);
    case (unit)
      UNIT_ALU: unit_wsel = WSEL_ALU;
      UNIT_MUL: unit_wsel = WSEL_MUL;
      UNIT_SHF: unit_wsel = WSEL_SHF;
      default:  unit_wsel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cu_func_decode.sv
// Combinational decode of unit + function code into per-unit control lines.
module cu_func_decode
  import cu_pkg::*;
(
  input  logic [1:0] unit_i,
  input  logic [6:0] func_i,
  output cu_ctrl_t   ctrl_o
);

  // Only the selected unit gets an enable and its fields; everything else stays 0
  always_comb begin
    ctrl_o = '0;
    case (unit_i)
      UNIT_ALU: begin
        ctrl_o.alu_en  = 1'b1;
        ctrl_o.alu_log = func_i[ALU_LOG_BIT];
        ctrl_o.alu_hc  = func_i[ALU_HC_LSB +: 2];
        ctrl_o.alu_sc  = func_i[ALU_SC_LSB +: 3];
        ctrl_o.alu_sat = func_i[ALU_SAT_BIT];
      end
      UNIT_MUL: begin
        ctrl_o.mul_en    = 1'b1;
        ctrl_o.mul_otreg = func_i[MUL_OTREG_BIT];
        ctrl_o.mul_dtsts = func_i[MUL_DTSTS_LSB +: 4];
        ctrl_o.mul_cls   = func_i[MUL_CLS_LSB +: 2];
      end
      UNIT_SHF: begin
        ctrl_o.shf_en  = 1'b1;
        ctrl_o.shf_cls = func_i[SHF_CLS_LSB +: 2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Two-stage issue/write-back sequencer with RAW stall and write-port arbitration.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned SIGNAL_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [1:0]               op_unit,
  input  logic [ADDRESS_WIDTH-1:0] op_dst,
  input  logic [ADDRESS_WIDTH-1:0] op_srcx,
  input  logic [ADDRESS_WIDTH-1:0] op_srcy,
  input  logic [6:0]               op_func,
  output logic                     op_err,
  output logic                     ps_alu_en,
  output logic                     ps_alu_log,
  output logic                     ps_alu_sat,
  output logic [1:0]               ps_alu_hc,
  output logic [2:0]               ps_alu_sc,
  output logic                     ps_mul_en,
  output logic                     ps_mul_otreg,
  output logic [3:0]               ps_mul_dtsts,
  output logic [1:0]               ps_mul_cls,
  output logic                     ps_shf_en,
  output logic [1:0]               ps_shf_cls,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
  output logic                     ps_xb_w_bcEn,
  input  logic                     bc_req,
  input  logic [ADDRESS_WIDTH-1:0] bc_wadd,
  output logic                     bc_gnt,
  output logic                     cu_busy
);

  logic                     accept;
  cu_ctrl_t                 dec_ctrl;

  // Issue stage; srcx/srcy live in the read-address registers, func in ctrl_q
  logic                     iss_v_q, iss_v_d;
  logic [1:0]               iss_unit_q, iss_unit_d;
  logic [ADDRESS_WIDTH-1:0] iss_dst_q, iss_dst_d;
  logic [ADDRESS_WIDTH-1:0] raddx_q, raddx_d;
  logic [ADDRESS_WIDTH-1:0] raddy_q, raddy_d;
  cu_ctrl_t                 ctrl_q, ctrl_d;
  logic                     err_q, err_d;

  // Write-back stage
  logic                     wb_v_q, wb_v_d;
  logic [SIGNAL_WIDTH-1:0]  wb_sel_q, wb_sel_d;
  logic [ADDRESS_WIDTH-1:0] wb_dst_q, wb_dst_d;

  // Stall only against the issue stage; the write-back result lands before any read
  assign op_ready = ~(iss_v_q & ((op_srcx == iss_dst_q) | (op_srcy == iss_dst_q)));
  assign accept   = op_valid & op_ready;

  cu_func_decode u_decode (
    .unit_i (op_unit),
    .func_i (op_func),
    .ctrl_o (dec_ctrl)
  );

  // Next-state for both pipeline stages; read addresses hold when idle
  always_comb begin
    iss_v_d    = accept;
    iss_unit_d = iss_unit_q;
    iss_dst_d  = iss_dst_q;
    raddx_d    = raddx_q;
    raddy_d    = raddy_q;
    ctrl_d     = '0;
    err_d      = 1'b0;
    if (accept) begin
      iss_unit_d = op_unit;
      iss_dst_d  = op_dst;
      raddx_d    = op_srcx;
      raddy_d    = op_srcy;
      ctrl_d     = dec_ctrl;
      err_d      = (op_unit == UNIT_RSV);
    end
    wb_v_d   = iss_v_q & (iss_unit_q != UNIT_RSV);
    wb_sel_d = wb_v_d ? SIGNAL_WIDTH'(unit_wsel(iss_unit_q)) : '0;
    wb_dst_d = iss_dst_q;
  end

  // Pipeline registers; reset discards both stages immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q    <= 1'b0;
      iss_unit_q <= '0;
      iss_dst_q  <= '0;
      raddx_q    <= '0;
      raddy_q    <= '0;
      ctrl_q     <= '0;
      err_q      <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_sel_q   <= '0;
      wb_dst_q   <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_unit_q <= iss_unit_d;
      iss_dst_q  <= iss_dst_d;
      raddx_q    <= raddx_d;
      raddy_q    <= raddy_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      wb_v_q     <= wb_v_d;
      wb_sel_q   <= wb_sel_d;
      wb_dst_q   <= wb_dst_d;
    end
  end

  assign op_err       = err_q;
  assign ps_alu_en    = ctrl_q.alu_en;
  assign ps_alu_log   = ctrl_q.alu_log;
  assign ps_alu_sat   = ctrl_q.alu_sat;
  assign ps_alu_hc    = ctrl_q.alu_hc;
  assign ps_alu_sc    = ctrl_q.alu_sc;
  assign ps_mul_en    = ctrl_q.mul_en;
  assign ps_mul_otreg = ctrl_q.mul_otreg;
  assign ps_mul_dtsts = ctrl_q.mul_dtsts;
  assign ps_mul_cls   = ctrl_q.mul_cls;
  assign ps_shf_en    = ctrl_q.shf_en;
  assign ps_shf_cls   = ctrl_q.shf_cls;
  assign ps_xb_raddx  = raddx_q;
  assign ps_xb_raddy  = raddy_q;
  assign ps_xb_w_cuEn = wb_sel_q;

  // Compute write-back owns the port; bus-connect only fills idle write cycles.
  // Gated by rst so the combinational paths also read as reset values.
  assign bc_gnt       = ~rst & bc_req & ~wb_v_q;
  assign ps_xb_w_bcEn = bc_gnt;
  assign ps_xb_wadd   = rst ? '0 : (wb_v_q ? wb_dst_q : bc_wadd);
  assign cu_busy      = iss_v_q | wb_v_q;

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Issue and write-back controller for the compute unit. Accepts one decoded compute instruction per cycle over a valid/ready handshake. Drives the ALU, multiplier and shifter enable/control lines plus the crossbar read/write addresses. Runs a two-stage issue→write-back pipeline with a read-after-write hazard stall, and arbitrates the single register-file write port between compute write-back and bus-connect writes.

## Interface
- ADDRESS_WIDTH, 4, register-file address width
- SIGNAL_WIDTH, 3, crossbar compute-write one-hot width; bit0 ALU, bit1 shifter, bit2 multiplier
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  instruction offered
- op_ready  out  1  instruction accepted when op_valid & op_ready at a rising edge
- op_unit  in  2  0 ALU, 1 multiplier, 2 shifter, 3 reserved
- op_dst, op_srcx, op_srcy  in  ADDRESS_WIDTH each  destination / x / y register
- op_func  in  7  unit function code; ALU: {sat, sc[2:0], hc[1:0], log}; multiplier: {cls[1:0], dtsts[3:0], otreg}; shifter: {5'b0, cls[1:0]}
- op_err  out  1  one-cycle pulse: reserved unit accepted
- ps_alu_en, ps_alu_log, ps_alu_sat  out  1  ALU controls
- ps_alu_hc  out  2, ps_alu_sc  out  3  ALU controls
- ps_mul_en, ps_mul_otreg  out  1, ps_mul_dtsts  out  4, ps_mul_cls  out  2  multiplier controls
- ps_shf_en  out  1, ps_shf_cls  out  2  shifter controls
- ps_xb_raddx, ps_xb_raddy  out  ADDRESS_WIDTH  read addresses
- ps_xb_wadd  out  ADDRESS_WIDTH  write address
- ps_xb_w_cuEn  out  SIGNAL_WIDTH  one-hot compute write select
- ps_xb_w_bcEn  out  1  bus-connect write enable
- bc_req  in  1, bc_wadd  in  ADDRESS_WIDTH  bus-connect write request and target
- bc_gnt  out  1  bus-connect write performed this cycle
- cu_busy  out  1  issue or write-back stage occupied

## Operation
- Pipeline registers: issue stage (iss_v, unit, dst, srcx, srcy, func) and write-back stage (wb_v, unit, dst).
- Accept at edge E0 loads the issue stage. The cycle after E0 drives exactly one ps_*_en and that unit's controls from func, plus raddx=srcx and raddy=srcy. All other unit controls are 0.
- At E1 the issue stage moves to write-back. In the cycle after E1, ps_xb_w_cuEn = one-hot(unit) and ps_xb_wadd = dst.
- Reserved unit: accepted, no enable, no write-back, op_err pulses during its issue cycle.
- Hazard: op_ready = ~(iss_v & (op_srcx==iss_dst | op_srcy==iss_dst)). This is combinational from op fields; op_valid does not depend on op_ready.
- No stall is needed against the write-back stage: the register file writes at the edge ending the write-back cycle, and the hazard rule already covers the one-cycle gap.
- Arbitration: compute write-back has priority. bc_gnt = ps_xb_w_bcEn = bc_req & ~wb_v. When granted, ps_xb_wadd = bc_wadd. bc_req is held until bc_gnt.
- Idle: raddx/raddy hold last values, wadd = bc_wadd; en/select outputs are 0.
- cu_busy = iss_v | wb_v.

## Timing
- Reset: all enables, ps_xb_w_cuEn, ps_xb_w_bcEn, bc_gnt, op_err = 0; all addresses and controls = 0; iss_v = wb_v = 0; op_ready = 1.
- Latency: accept → unit enable 1 cycle; accept → register write 2 cycles. Throughput 1 op/cycle without hazards.
- Dependent back-to-back op incurs exactly one stall cycle.
- Reset mid-operation: issue and write-back contents are discarded, no partial write occurs, and outputs return to reset values immediately.
- Simultaneous bc_req and wb_v: bus-connect waits exactly until wb_v is 0. A continuous dependency-free op stream can starve the bus connect; this is accepted as the intended behaviour.

## Structure
- Shared package cu_pkg: unit-code constants (UNIT_ALU=0, UNIT_MUL=1, UNIT_SHF=2), one-hot write-select constants, and op_func field offsets per unit.
- One sub-module: cu_func_decode (combinational; unit + func → all ps_alu_*/ps_mul_*/ps_shf_* lines). The sequencer registers its outputs.
- Total RTL size is about 200 lines.

## Test plan
- Reset, then ALU op dst=3, srcx=1, srcy=2, func=7'b0000001, accepted at E0. Required: cycle after E0 has ps_alu_en=1, ps_alu_log=1, raddx=1, raddy=2. Next cycle has ps_xb_w_cuEn=3'b001, wadd=3.
- Multiplier op dst=5, then dependent shifter op srcx=5 offered immediately. Required: op_ready=0 for one cycle, shifter issued one cycle later, cuEn=3'b100 then 3'b010 on consecutive write-back cycles.
- Four independent ops back-to-back. Required: op_ready stays 1, four consecutive enable cycles, four consecutive write-backs.
- bc_req with bc_wadd=9 raised during an ALU write-back. Required: bc_gnt=0 that cycle, then bc_gnt=1 with ps_xb_w_bcEn=1 and wadd=9 the next idle cycle.
- op_unit=3 accepted. Required: op_err pulses once, and no enable or write occurs.
- rst asserted between accept and write-back. Required: all outputs 0 asynchronously, no cuEn pulse after rst deasserts, op_ready=1.
